// File: rtl/solenoid_bank_if.sv
// APB3 slave bus bundle for the solenoid pulse controller.
// The master drives the request signals; the slave returns read data and response.
interface solenoid_bank_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/solenoid_bank.sv
// Multi-channel APB3 solenoid pulse controller: per-channel programmable pulse
// length and coil-cooldown holdoff, with sticky completion flags and a level irq.
module solenoid_bank #(
  parameter int          NCH         = 4,
  parameter int          CNT_W       = 32,
  parameter logic [11:0] BASE_ADDR   = 12'h100,
  parameter int unsigned DEF_PULSE   = 50000000,
  parameter int unsigned DEF_HOLDOFF = 200000
) (
  input  logic               PCLK,
  input  logic               PRESERN,
  solenoid_bank_if.slave     apb,
  output logic [NCH-1:0]     trigger,
  output logic               irq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  logic             w_hit;
  logic             w_wr;
  logic             w_rd;
  logic [7:0]       w_off;
  logic [NCH-1:0]   w_wdat_n;
  logic [CNT_W-1:0] w_wdat_c;
  logic             w_unused_addr;

  assign w_hit         = (apb.PADDR[11:8] == BASE_ADDR[11:8]);
  assign w_off         = apb.PADDR[7:0];
  assign w_wr          = apb.PSEL & apb.PENABLE & apb.PWRITE & w_hit;
  assign w_rd          = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE & w_hit;
  assign w_wdat_n      = apb.PWDATA[NCH-1:0];
  assign w_wdat_c      = apb.PWDATA[CNT_W-1:0];
  assign w_unused_addr = ^apb.PADDR[31:12];

  state_t           r_state [NCH];
  logic [CNT_W-1:0] r_cnt   [NCH];
  logic [CNT_W-1:0] r_plen  [NCH];
  logic [CNT_W-1:0] r_hold  [NCH];
  logic [NCH-1:0]   r_trig;
  logic [NCH-1:0]   r_done;
  logic [NCH-1:0]   r_drop;
  logic [NCH-1:0]   r_irq_en;
  logic [31:0]      r_prdata;

  logic [NCH-1:0] w_fire;
  logic [NCH-1:0] w_abort;
  logic [NCH-1:0] w_done_clr;
  logic [NCH-1:0] w_drop_clr;
  logic           w_wr_irqen;
  logic [NCH-1:0] w_wr_plen;
  logic [NCH-1:0] w_wr_hold;
  logic [NCH-1:0] w_active;
  logic [NCH-1:0] w_holding;
  logic [NCH-1:0] w_done_set;
  logic [NCH-1:0] w_drop_set;

  always_comb begin
    w_fire     = (w_wr && w_off == 8'h00) ? w_wdat_n : '0;
    w_abort    = (w_wr && w_off == 8'h04) ? w_wdat_n : '0;
    w_done_clr = (w_wr && w_off == 8'h0C) ? w_wdat_n : '0;
    w_drop_clr = (w_wr && w_off == 8'h14) ? w_wdat_n : '0;
    w_wr_irqen = w_wr && (w_off == 8'h10);
    w_wr_plen  = '0;
    w_wr_hold  = '0;
    w_active   = '0;
    w_holding  = '0;
    w_done_set = '0;
    w_drop_set = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr_plen[i] = w_wr && (w_off == 8'(32 + 8 * i));
      w_wr_hold[i] = w_wr && (w_off == 8'(36 + 8 * i));
      w_active[i]  = (r_state[i] == S_ACTIVE);
      w_holding[i] = (r_state[i] == S_HOLD);
      // An abort landing on the expiry cycle suppresses completion.
      w_done_set[i] = w_active[i] && (r_cnt[i] == CNT_W'(1)) && !w_abort[i];
      w_drop_set[i] = w_fire[i] && ((r_state[i] != S_IDLE) || (r_plen[i] == '0));
    end
  end

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_off)
      8'h08: begin
        w_rdata[NCH-1:0]   = w_active;
        w_rdata[8 +: NCH]  = w_holding;
        w_rdata[16 +: NCH] = r_drop;
      end
      8'h0C:   w_rdata[NCH-1:0] = r_done;
      8'h10:   w_rdata[NCH-1:0] = r_irq_en;
      default: w_rdata = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (w_off == 8'(32 + 8 * i)) w_rdata = 32'(r_plen[i]);
      if (w_off == 8'(36 + 8 * i)) w_rdata = 32'(r_hold[i]);
    end
  end

  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      r_trig   <= '0;
      r_done   <= '0;
      r_drop   <= '0;
      r_irq_en <= '0;
      r_prdata <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
        r_plen[i]  <= CNT_W'(DEF_PULSE);
        r_hold[i]  <= CNT_W'(DEF_HOLDOFF);
      end
    end else begin
      // New completions/drops take priority over a same-cycle W1C.
      r_done <= (r_done & ~w_done_clr) | w_done_set;
      r_drop <= (r_drop & ~w_drop_clr) | w_drop_set;
      if (w_wr_irqen) r_irq_en <= w_wdat_n;
      if (w_rd)       r_prdata <= w_rdata;
      for (int i = 0; i < NCH; i++) begin
        if (w_wr_plen[i]) r_plen[i] <= w_wdat_c;
        if (w_wr_hold[i]) r_hold[i] <= w_wdat_c;
        case (r_state[i])
          S_IDLE: begin
            if (w_fire[i] && (r_plen[i] != '0)) begin
              r_state[i] <= S_ACTIVE;
              r_cnt[i]   <= r_plen[i];
              r_trig[i]  <= 1'b1;
            end
          end
          S_ACTIVE: begin
            if (w_abort[i] || (r_cnt[i] == CNT_W'(1))) begin
              r_trig[i] <= 1'b0;
              if (r_hold[i] == '0) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
              end else begin
                r_state[i] <= S_HOLD;
                r_cnt[i]   <= r_hold[i];
              end
            end else begin
              r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
          end
          S_HOLD: begin
            if (r_cnt[i] == CNT_W'(1)) begin
              r_state[i] <= S_IDLE;
              r_cnt[i]   <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            r_state[i] <= S_IDLE;
            r_cnt[i]   <= '0;
            r_trig[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trigger     = r_trig;
  assign irq         = |(r_done & r_irq_en);
  assign apb.PRDATA  = r_prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

endmodule

// File: tb/tb_solenoid_bank.sv
// Bench for solenoid_bank: directed scenarios plus randomized APB traffic, checked
// against a per-channel timeline model (pulse start/end and holdoff end edges).
module tb_solenoid_bank;
  localparam int          NCH   = 4;
  localparam logic [11:0] BASE  = 12'h100;
  localparam int          DEF_P = 50000000;
  localparam int          DEF_H = 200000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] trigger;
  logic           irq;

  solenoid_bank_if apb();

  solenoid_bank #(
    .NCH(NCH), .CNT_W(32), .BASE_ADDR(BASE),
    .DEF_PULSE(DEF_P), .DEF_HOLDOFF(DEF_H)
  ) dut (
    .PCLK(clk), .PRESERN(rst), .apb(apb), .trigger(trigger), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Timeline model: after edge k a channel is high when m_start <= k < m_end,
  // in holdoff when m_end <= k < m_hend, idle otherwise.
  int             m_start   [NCH];
  int             m_end     [NCH];
  int             m_hend    [NCH];
  int             m_done_at [NCH];
  bit             m_done    [NCH];
  bit             m_drop    [NCH];
  int             m_plen    [NCH];
  int             m_hold    [NCH];
  logic [NCH-1:0] m_irq_en;
  int             hi_cnt    [NCH];

  logic [7:0] roffs [12] = '{8'h08, 8'h0C, 8'h10, 8'h18, 8'h20, 8'h24,
                             8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_start[i] = -1; m_end[i] = -1; m_hend[i] = -1; m_done_at[i] = -1;
      m_done[i] = 0; m_drop[i] = 0; m_plen[i] = DEF_P; m_hold[i] = DEF_H;
      hi_cnt[i] = 0;
    end
    m_irq_en = '0;
  endtask

  function automatic bit done_eff(input int i, input int k);
    return m_done[i] || (m_done_at[i] >= 0 && m_done_at[i] <= k);
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] off, input int k);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) begin
      if (off == 8'h08) begin
        v[i]      = (m_start[i] <= k) && (k < m_end[i]);
        v[8 + i]  = (m_end[i] <= k) && (k < m_hend[i]);
        v[16 + i] = m_drop[i];
      end
      if (off == 8'h0C) v[i] = done_eff(i, k);
      if (off == 8'h10) v[i] = m_irq_en[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (off == 8'(32 + 8 * i)) v = 32'(m_plen[i]);
      if (off == 8'(36 + 8 * i)) v = 32'(m_hold[i]);
    end
    return v;
  endfunction

  task automatic model_write(input logic [7:0] off, input logic [31:0] d, input int s);
    for (int i = 0; i < NCH; i++) begin
      if (off == 8'h00 && d[i]) begin
        if ((s - 1 >= m_hend[i]) && (m_plen[i] != 0)) begin
          if (m_done_at[i] >= 0) m_done[i] = 1;
          m_start[i] = s;
          m_end[i] = s + m_plen[i];
          m_hend[i] = m_end[i] + m_hold[i];
          m_done_at[i] = m_end[i];
        end else begin
          m_drop[i] = 1;
        end
      end
      if (off == 8'h04 && d[i] && (m_start[i] <= s - 1) && (s - 1 < m_end[i])) begin
        m_end[i] = s;
        m_hend[i] = s + m_hold[i];
        m_done_at[i] = -1;
      end
      if (off == 8'h0C && d[i]) begin
        if (m_done_at[i] >= 0 && m_done_at[i] <= s) begin
          m_done[i] = (m_done_at[i] == s);
          m_done_at[i] = -1;
        end else begin
          m_done[i] = 0;
        end
      end
      if (off == 8'h14 && d[i]) m_drop[i] = 0;
      if (off == 8'(32 + 8 * i)) m_plen[i] = int'(d);
      if (off == 8'(36 + 8 * i)) begin
        m_hold[i] = int'(d);
        if (m_end[i] > s) m_hend[i] = m_end[i] + int'(d);
      end
    end
    if (off == 8'h10) m_irq_en = d[NCH-1:0];
  endtask

  task automatic tick();
    logic [NCH-1:0] et;
    logic           ei;
    @(negedge clk);
    ei = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      et[i] = (m_start[i] <= cyc) && (cyc < m_end[i]);
      ei = ei | (done_eff(i, cyc) & m_irq_en[i]);
      if (trigger[i] === 1'b1) hi_cnt[i]++;
    end
    chk("trigger", 32'(trigger), 32'(et));
    chk("irq", 32'(irq), 32'(ei));
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    tick();
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = {20'h0, a}; apb.PWDATA = d;
    tick();
    apb.PENABLE = 1'b1;
    @(posedge clk);
    #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    if (a[11:8] == BASE[11:8]) model_write(a[7:0], d, cyc);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    apb_wr({BASE[11:8], off}, d);
  endtask

  task automatic apb_rd(input logic [7:0] off, output logic [31:0] d, output int k);
    tick();
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = {20'h0, BASE[11:8], off};
    tick();
    apb.PENABLE = 1'b1;
    d = apb.PRDATA;
    k = cyc - 1;
    @(posedge clk);
    #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, output logic [31:0] d);
    int k;
    apb_rd(off, d, k);
    chk(tag, d, exp_read(off, k));
  endtask

  task automatic clr_hi();
    for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int          s_fire;
    int          t_irq;
    int          ch;
    logic [31:0] rv;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    tick();
    chk("rst_trigger", 32'(trigger), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("pready", 32'(apb.PREADY), 32'h1);
    chk("pslverr", 32'(apb.PSLVERR), 32'h0);
    rd_chk("rst_status", 8'h08, v);
    rd_chk("rst_done", 8'h0C, v);
    rd_chk("rst_irqen", 8'h10, v);
    rd_chk("rst_plen3", 8'h38, v);
    chk("rst_plen3_lit", v, 32'd50000000);
    rd_chk("rst_hold0", 8'h24, v);
    chk("rst_hold0_lit", v, 32'd200000);
    rd_chk("unmapped_18", 8'h18, v);
    chk("unmapped_18_lit", v, 32'h0);

    // Single pulse: 5 high, 3 holdoff
    wr(8'h20, 32'd5);
    wr(8'h24, 32'd3);
    clr_hi();
    wr(8'h00, 32'h1);
    for (int n = 0; n < 5; n++) begin
      rd_chk("p0_status", 8'h08, v);
      if (n == 3) chk("p0_status_hold_lit", v, 32'h100);
    end
    repeat (4) tick();
    chk("p0_width", 32'(hi_cnt[0]), 32'd5);
    rd_chk("p0_done", 8'h0C, v);
    chk("p0_done_lit", v, 32'h1);

    // Fire while active and while in holdoff is dropped
    clr_hi();
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h1);
    repeat (4) tick();
    chk("drop_width", 32'(hi_cnt[0]), 32'd5);
    rd_chk("drop_status", 8'h08, v);
    chk("drop_bit16", 32'(v[16]), 32'h1);
    wr(8'h14, 32'h1);
    rd_chk("dropclr_status", 8'h08, v);
    chk("dropclr_bit16", 32'(v[16]), 32'h0);

    // Abort after 10 cycles
    wr(8'h28, 32'd100);
    wr(8'h2C, 32'd20);
    clr_hi();
    wr(8'h00, 32'h2);
    repeat (8) tick();
    wr(8'h04, 32'h2);
    repeat (3) tick();
    chk("abort_width", 32'(hi_cnt[1]), 32'd10);
    rd_chk("abort_done", 8'h0C, v);
    chk("abort_done1", 32'(v[1]), 32'h0);
    rd_chk("abort_status", 8'h08, v);
    chk("abort_hold_bit9", 32'(v[9]), 32'h1);
    repeat (25) tick();

    // Four independent pulses with interrupts
    wr(8'h0C, 32'hF);
    wr(8'h10, 32'hF);
    chk("irq_clear_start", 32'(irq), 32'h0);
    wr(8'h20, 32'd4);  wr(8'h24, 32'd2);
    wr(8'h28, 32'd6);  wr(8'h2C, 32'd2);
    wr(8'h30, 32'd8);  wr(8'h34, 32'd0);
    wr(8'h38, 32'd10); wr(8'h3C, 32'd1);
    clr_hi();
    wr(8'h00, 32'hF);
    s_fire = cyc;
    t_irq = -1;
    for (int n = 0; n < 14; n++) begin
      tick();
      if (irq === 1'b1 && t_irq < 0) t_irq = cyc - s_fire;
    end
    chk("irq_first_rise", 32'(t_irq), 32'd4);
    chk("multi_w0", 32'(hi_cnt[0]), 32'd4);
    chk("multi_w1", 32'(hi_cnt[1]), 32'd6);
    chk("multi_w2", 32'(hi_cnt[2]), 32'd8);
    chk("multi_w3", 32'(hi_cnt[3]), 32'd10);
    rd_chk("multi_done", 8'h0C, v);
    chk("multi_done_lit", v, 32'hF);
    wr(8'h0C, 32'hF);
    tick();
    chk("irq_after_w1c", 32'(irq), 32'h0);

    // Zero length fire is dropped; foreign window ignored
    wr(8'h30, 32'd0);
    wr(8'h00, 32'h4);
    rd_chk("zero_len_status", 8'h08, v);
    chk("zero_len_drop18", 32'(v[18]), 32'h1);
    apb_wr(12'h200, 32'hF);
    repeat (3) tick();
    chk("foreign_no_trig", 32'(trigger), 32'h0);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      ch = $urandom_range(0, NCH - 1);
      case ($urandom_range(0, 9))
        0, 1, 2: wr(8'h00, 32'($urandom_range(1, 15)));
        3:       wr(8'h04, 32'($urandom_range(1, 15)));
        4:       wr(8'(32 + 8 * ch), ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 12)));
        5:       wr(8'(36 + 8 * ch), 32'($urandom_range(0, 6)));
        6:       rd_chk("rand_reg", roffs[$urandom_range(0, 11)], rv);
        7:       wr(($urandom_range(0, 1) == 0) ? 8'h0C : 8'h14, 32'($urandom_range(0, 15)));
        8:       wr(8'h10, 32'($urandom_range(0, 15)));
        default: repeat ($urandom_range(0, 4)) tick();
      endcase
      rd_chk("rand_status", 8'h08, rv);
      if ((it % 4) == 0) rd_chk("rand_done", 8'h0C, rv);
    end

    // Asynchronous reset in the middle of a pulse
    repeat (30) tick();
    wr(8'h20, 32'd20);
    wr(8'h00, 32'h1);
    repeat (3) tick();
    chk("pre_rst_trig0", 32'(trigger[0]), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_trig", 32'(trigger), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    rd_chk("post_rst_plen0", 8'h20, v);
    chk("post_rst_plen0_lit", v, 32'd50000000);
    rd_chk("post_rst_hold0", 8'h24, v);
    chk("post_rst_hold0_lit", v, 32'd200000);
    rd_chk("post_rst_status", 8'h08, v);
    chk("post_rst_status_lit", v, 32'h0);
    rd_chk("post_rst_done", 8'h0C, v);
    rd_chk("post_rst_irqen", 8'h10, v);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/solenoid_bank.md
Name: solenoid_bank

Overview:
- Multi-channel APB3 solenoid pulse controller; generalises the single-shot fixed-width trigger peripheral.
- Each of NCH channels has a software-programmable pulse length and a holdoff (coil cooldown) period.
- Firing, aborting, status readback and a completion interrupt are provided through one APB3 slave window on the SmartFusion fabric bus.

Parameters:
- NCH, 4, number of solenoid channels (1..8).
- CNT_W, 32, width of pulse/holdoff counters and length registers.
- BASE_ADDR, 12'h100, window base; must be 256-byte aligned.
- DEF_PULSE, 50000000, reset value of every PULSE_LEN register (cycles).
- DEF_HOLDOFF, 200000, reset value of every HOLDOFF register (cycles).

Ports:
- PCLK  in  1  sole clock, rising edge.
- PRESERN  in  1  reset; asynchronous, active-high (1 = reset asserted).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  32  address; only [11:0] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- trigger  out  NCH  solenoid drive, one bit per channel, registered.
- irq  out  1  level interrupt, OR of (DONE & IRQ_EN).

Behaviour:
- Decode: hit when PADDR[11:8] == BASE_ADDR[11:8]; offset = PADDR[7:0].
- Write strobe: PSEL & PENABLE & PWRITE & hit; one strobe per transfer.
- Read capture: PRDATA loaded on PSEL & ~PENABLE & ~PWRITE & hit; valid in access phase.
- Register map:
  - 0x00 FIRE (W): bit i = 1 requests fire of channel i.
  - 0x04 ABORT (W): bit i = 1 aborts channel i.
  - 0x08 STATUS (R): [NCH-1:0] active; [8+NCH-1:8] holdoff; [16+NCH-1:16] dropped.
  - 0x0C DONE (R/W1C): sticky pulse-completed bits.
  - 0x10 IRQ_EN (R/W): [NCH-1:0].
  - 0x14 DROP_CLR (W1C): clears dropped bits.
  - 0x20+8i PULSE_LEN[i] (R/W).
  - 0x24+8i HOLDOFF[i] (R/W).
  - Unmapped offsets: writes ignored, reads return 0. Register bits beyond NCH/CNT_W read 0.
- Reset (asynchronous): trigger=0, PRDATA=0, irq=0, all channels IDLE, counters=0, DONE/dropped/IRQ_EN=0, PULSE_LEN=DEF_PULSE, HOLDOFF=DEF_HOLDOFF.
- Per-channel FSM: IDLE -> ACTIVE -> HOLDOFF -> IDLE.
  - IDLE, FIRE bit set, PULSE_LEN != 0: latch length into counter; enter ACTIVE; trigger[i] rises at the edge after the write strobe (latency 1).
  - ACTIVE: trigger high exactly PULSE_LEN cycles; counter decrements. At expiry: trigger low, DONE[i] set, load HOLDOFF.
  - HOLDOFF: lasts HOLDOFF cycles with trigger low, then returns to IDLE. HOLDOFF = 0 returns to IDLE immediately.
  - FIRE while ACTIVE or HOLDOFF: ignored; dropped[i] set.
  - FIRE with PULSE_LEN = 0: ignored; dropped[i] set.
- Abort:
  - In ACTIVE: trigger low next edge; enter HOLDOFF; DONE not set.
  - In HOLDOFF or IDLE: no effect.
  - Abort in the same cycle as pulse expiry: abort wins, DONE not set.
- Register writes: PULSE_LEN/HOLDOFF written mid-operation take effect only at the next fire or holdoff load.
- Channels are fully independent; a multi-bit FIRE starts all qualifying channels in the same cycle.
- Set vs clear on same cycle: set wins for DONE and dropped versus W1C.
- irq is combinational from registered DONE and IRQ_EN; no glitch paths through APB inputs.
- Counter arithmetic: unsigned CNT_W; no wrap, since decrement stops at terminal state.
- Reset mid-pulse: trigger drops asynchronously.

Test Plan:
- Reset, PULSE_LEN[0]=5, HOLDOFF[0]=3, FIRE=0x1 -> trigger[0] high exactly 5 cycles starting 1 cycle after strobe; DONE=0x1; STATUS holdoff bit 8 set for 3 cycles.
- FIRE=0x1 issued during ACTIVE and again during HOLDOFF -> trigger pulse unchanged; STATUS bit 16 =1; DROP_CLR=0x1 -> bit 16 =0.
- PULSE_LEN[1]=100, FIRE=0x2, ABORT=0x2 after 10 cycles -> trigger[1] high 10 cycles then low; DONE[1]=0; holdoff entered.
- IRQ_EN=0xF, FIRE=0xF with lengths 4,6,8,10 -> independent pulses of those widths; irq rises on first completion; W1C DONE=0xF after all complete -> irq=0.
- PULSE_LEN[2]=0, FIRE=0x4 -> no pulse, dropped[2]=1. Read of offset 0x18 -> 0. Read of PULSE_LEN[3] after reset -> 50000000.
- Assert PRESERN mid-pulse -> trigger=0 asynchronously, all registers at defaults after release.
